// File: rtl/arm_register_file.sv
// ARM register bank R0-R15: one synchronous write port, three combinational
// read ports with optional write forwarding, and a dedicated R15 program-counter path.
module arm_register_file #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned PC_STEP        = 4,
  parameter int unsigned PC_READ_OFFSET = 8,
  parameter bit          BYPASS         = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [3:0]       wsel,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pc_inc,
  input  logic             pc_ld,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [3:0]       sa,
  input  logic [3:0]       sb,
  input  logic [3:0]       sc,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] pc_out
);

  localparam logic [3:0]       PC_IDX   = 4'd15;
  localparam logic [WIDTH-1:0] PC_INCR  = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0] PC_RDOFF = WIDTH'(PC_READ_OFFSET);

  logic [WIDTH-1:0] gpr [15];
  logic [WIDTH-1:0] pc_q;

  logic             wr_gpr;
  logic             wr_pc;
  logic [WIDTH-1:0] wdata_aligned;
  logic [WIDTH-1:0] pc_ld_aligned;

  assign wr_gpr        = we && (wsel != PC_IDX);
  assign wr_pc         = we && (wsel == PC_IDX);
  assign wdata_aligned = {wdata[WIDTH-1:2], 2'b00};
  assign pc_ld_aligned = {pc_in[WIDTH-1:2], 2'b00};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the whole bank is reset here because software may read any register
  // straight after reset; this keeps the array out of dedicated RAM macros.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) gpr[i] <= '0;
      pc_q <= '0;
    end else begin
      if (wr_gpr) gpr[wsel] <= wdata;
      // Exactly one R15 action per edge: write port, then branch load, then increment.
      if (wr_pc)       pc_q <= wdata_aligned;
      else if (pc_ld)  pc_q <= pc_ld_aligned;
      else if (pc_inc) pc_q <= pc_q + PC_INCR;
    end
  end

  logic [WIDTH-1:0] pc_read;
  logic [WIDTH-1:0] fwd_data;
  logic             fwd_en;
  logic [3:0]       rsel [3];
  logic [WIDTH-1:0] rdata [3];

  assign pc_read  = pc_q + PC_RDOFF;
  assign fwd_data = wr_pc ? (wdata_aligned + PC_RDOFF) : wdata;
  assign fwd_en   = BYPASS && we && !reset;

  assign rsel[0] = sa;
  assign rsel[1] = sb;
  assign rsel[2] = sc;

  // NOTE: each output gets a default before any conditional override so
  // always_comb never infers a latch.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdata[p] = (rsel[p] == PC_IDX) ? pc_read : gpr[rsel[p]];
      if (fwd_en && (rsel[p] == wsel)) rdata[p] = fwd_data;
    end
  end

  assign A      = rdata[0];
  assign B      = rdata[1];
  assign C      = rdata[2];
  assign pc_out = pc_q;

endmodule

// File: tb/tb_arm_register_file.sv
// Directed bench for arm_register_file: a forwarding instance and a
// non-forwarding instance share stimulus and are checked against hand values.
module tb_arm_register_file;

  logic        clk = 1'b0;
  logic        reset, we, pc_inc, pc_ld;
  logic [3:0]  wsel, sa, sb, sc;
  logic [31:0] wdata, pc_in;
  logic [31:0] a1, b1, c1, pc1;
  logic [31:0] a0, b0, c0, pc0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arm_register_file #(.BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .we(we), .wsel(wsel), .wdata(wdata),
    .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_in(pc_in),
    .sa(sa), .sb(sb), .sc(sc), .A(a1), .B(b1), .C(c1), .pc_out(pc1)
  );

  arm_register_file #(.BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .reset(reset), .we(we), .wsel(wsel), .wdata(wdata),
    .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_in(pc_in),
    .sa(sa), .sb(sb), .sc(sc), .A(a0), .B(b0), .C(c0), .pc_out(pc0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a competing write and increment: reset must win.
    reset = 1'b1; we = 1'b1; wsel = 4'd3; wdata = 32'hDEADBEEF;
    pc_inc = 1'b1; pc_ld = 1'b0; pc_in = '0;
    sa = 4'd15; sb = 4'd3; sc = 4'd0;
    step();
    reset = 1'b0; we = 1'b0; pc_inc = 1'b0;
    #1;
    check("rst_pc", pc1, 32'h0);
    check("rst_a_r15", a1, 32'h8);
    check("rst_b_r3", b1, 32'h0);
    check("rst_c_r0", c1, 32'h0);
    check("rst_nobyp_a_r15", a0, 32'h8);

    // Fill R0..R14.
    for (int n = 0; n < 15; n++) begin
      we = 1'b1; wsel = 4'(n); wdata = 32'h100 + 32'(n);
      step();
    end
    we = 1'b0;
    for (int n = 0; n < 15; n++) begin
      sa = 4'(n); sb = 4'(14 - n); sc = 4'(n);
      #1;
      check($sformatf("rd_a_r%0d", n), a1, 32'h100 + 32'(n));
      check($sformatf("rd_b_r%0d", 14 - n), b1, 32'h100 + 32'(14 - n));
      check($sformatf("rd_c_r%0d", n), c1, 32'h100 + 32'(n));
    end
    sa = 4'd7; sb = 4'd7; sc = 4'd7;
    #1;
    check("same_a", a1, 32'h107);
    check("same_b", b1, 32'h107);
    check("same_c", c1, 32'h107);

    // Same-cycle forwarding of a general register.
    we = 1'b1; wsel = 4'd5; wdata = 32'h12345678; sa = 4'd5; sb = 4'd6;
    #1;
    check("byp_a_r5", a1, 32'h12345678);
    check("byp_b_r6", b1, 32'h106);
    check("nobyp_a_r5_pre", a0, 32'h105);
    step();
    we = 1'b0;
    #1;
    check("nobyp_a_r5_post", a0, 32'h12345678);
    check("byp_a_r5_post", a1, 32'h12345678);

    // Forwarding a write to R15 applies alignment and read offset.
    we = 1'b1; wsel = 4'd15; wdata = 32'h1003; sa = 4'd15;
    #1;
    check("byp_r15_a", a1, 32'h1008);
    check("byp_r15_pc_pre", pc1, 32'h0);
    check("nobyp_r15_a", a0, 32'h8);
    step();
    we = 1'b0;
    #1;
    check("wr_r15_pc", pc1, 32'h1000);
    check("wr_r15_a", a1, 32'h1008);

    // Load near the top, then increment through the wrap.
    pc_ld = 1'b1; pc_in = 32'hFFFFFFF4;
    #1;
    check("ld_no_fwd_a", a1, 32'h1008);
    step();
    pc_ld = 1'b0;
    check("ld_pc", pc1, 32'hFFFFFFF4);
    pc_inc = 1'b1;
    step();
    check("inc1_pc", pc1, 32'hFFFFFFF8);
    check("inc1_a_wrap", a1, 32'h0);
    step();
    check("inc2_pc", pc1, 32'hFFFFFFFC);
    step();
    pc_inc = 1'b0;
    check("inc3_pc_wrap", pc1, 32'h0);
    check("inc3_a", a1, 32'h8);

    // R15 priority: write port beats load beats increment.
    we = 1'b1; wsel = 4'd15; wdata = 32'h2003;
    pc_ld = 1'b1; pc_in = 32'h4000; pc_inc = 1'b1;
    step();
    check("prio_we_pc", pc1, 32'h2000);
    we = 1'b0; pc_in = 32'h4001;
    step();
    check("prio_ld_pc", pc1, 32'h4000);
    pc_ld = 1'b0;
    step();
    pc_inc = 1'b0;
    check("prio_inc_pc", pc1, 32'h4004);

    // Reset in the middle of activity.
    pc_ld = 1'b1; pc_in = 32'h80; we = 1'b1; wsel = 4'd7; wdata = 32'h55;
    step();
    pc_ld = 1'b0; we = 1'b0; sa = 4'd7;
    #1;
    check("mid_pre_pc", pc1, 32'h80);
    check("mid_pre_r7", a1, 32'h55);
    reset = 1'b1; pc_inc = 1'b1; we = 1'b1; wsel = 4'd7; wdata = 32'hAAAA;
    #1;
    check("mid_rst_no_fwd", a1, 32'h55);
    step();
    reset = 1'b0; we = 1'b0;
    #1;
    check("mid_rst_pc", pc1, 32'h0);
    check("mid_rst_r7", a1, 32'h0);
    step();
    pc_inc = 1'b0;
    check("mid_after_inc_pc", pc1, 32'h4);
    check("mid_nobyp_pc", pc0, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arm_register_file.md
Name: arm_register_file

Overview:
- ARM register bank R0–R15, 16 x 32-bit; feeds the 16-to-1 operand-select multiplexers that drive the datapath's A/B/C operand buses.
- One synchronous write port, three combinational read ports, and a dedicated program-counter path on R15: auto-increment, load, and a pipeline-offset read value.
- Sits between the instruction decoder (register selects) and the ALU/shifter operand inputs.

Parameters:
- WIDTH, 32: register width in bits.
- PC_STEP, 4: increment applied to R15 on pc_inc.
- PC_READ_OFFSET, 8: value added to R15 when R15 is read through any operand port. This models the ARM fetch-ahead.
- BYPASS, 1: 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return the stored value only.

Ports:
- clk, in, 1: single clock; all state updates on rising edge.
- reset, in, 1: reset is synchronous and active-high.
- we, in, 1: general write enable.
- wsel, in, 4: write register select.
- wdata, in, WIDTH: write data.
- pc_inc, in, 1: advance R15 by PC_STEP.
- pc_ld, in, 1: load R15 from pc_in.
- pc_in, in, WIDTH: branch target.
- sa, in, 4: read select, port A.
- sb, in, 4: read select, port B.
- sc, in, 4: read select, port C.
- A, out, WIDTH: operand A (combinational).
- B, out, WIDTH: operand B (combinational).
- C, out, WIDTH: operand C (combinational).
- pc_out, out, WIDTH: raw R15 value, no offset, to the fetch stage.

Behaviour:
- Reset, on a clk edge with reset=1:
  - All R0–R15 become 0; reset overrides every other input that cycle.
  - After reset: pc_out=0, and A/B/C read 0, except a read of R15 returns PC_READ_OFFSET (8).
- R0–R14: on a rising edge with we=1 and wsel=n (n<15), Rn <= wdata. Otherwise hold.
- R15 update priority, highest first, evaluated per edge:
  1. reset.
  2. we=1 with wsel=15: R15 <= {wdata[31:2],2'b00}.
  3. pc_ld=1: R15 <= {pc_in[31:2],2'b00}.
  4. pc_inc=1: R15 <= R15+PC_STEP, modulo 2^WIDTH; 0xFFFFFFFC+4 wraps to 0x00000000.
  5. Otherwise hold.
  - Exactly one action is applied per edge. pc_ld and pc_inc together loads; no increment is added.
- R15 is always word-aligned: bits [1:0] are forced 0 on every write/load path.
- Read ports:
  - Each port selects the register indexed by sa/sb/sc combinationally (zero latency).
  - Multiple ports may select the same register.
  - Sel 15 returns R15+PC_READ_OFFSET, modulo 2^WIDTH; R15=0xFFFFFFF8 reads as 0x00000000.
- Bypass (BYPASS=1):
  - If we=1 and sel==wsel for a port, that port returns wdata in the same cycle, before the edge.
  - For wsel=15 the forwarded value is {wdata[31:2],2'b00}+PC_READ_OFFSET.
  - pc_ld and pc_inc are never forwarded; the ports show the pre-edge R15.
  - Bypass is suppressed while reset=1.
- BYPASS=0: reads reflect state before the edge; the written value is visible from the next cycle.
- pc_out is always raw R15 with no offset and no bypass.
- Reset asserted mid-sequence (e.g. with we and pc_inc high) wins; no partial write occurs.
- No X propagation: the selects are full 4-bit decodes and all 16 cases are covered.

Test Plan:
- Reset: drive reset=1 for 1 edge with we=1, wsel=3, wdata=0xDEADBEEF → R3=0, pc_out=0, A (sa=15)=0x00000008.
- Write/readback: write R0..R14 with 0x100+n, then sweep sa/sb/sc over 0..14 → each port returns 0x100+n. Check A/B/C simultaneously on different and identical selects.
- Bypass: BYPASS=1, we=1, wsel=5, wdata=0x12345678, sa=5, before edge → A=0x12345678. With BYPASS=0 → A=old R5 until after the edge.
- PC increment and wrap: load pc_in=0xFFFFFFF4, then 3 pc_inc edges → pc_out 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; sa=15 reads 0x00000008 at the end.
- PC priority: same edge with we=1, wsel=15, wdata=0x2003, pc_ld=1, pc_in=0x4000, pc_inc=1 → pc_out=0x2000.
  - Next edge with pc_ld=1, pc_in=0x4001, pc_inc=1 → pc_out=0x4000.
- Reset mid-operation: R15=0x80, R7=0x55. Assert reset with pc_inc=1 and we=1, wsel=7 → pc_out=0, R7=0. Deassert, pc_inc → pc_out=4.
